// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: MEM-stage master for a word-wide, big-endian,
// byte-addressed data memory with fixed access latency and no acknowledge.
// Serves one load/store at a time; sub-word stores are read-modify-write.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/write/size/signed/addr/wdata   request from the pipeline
//   busy                        high whenever the unit is not idle
//   resp_valid/error/rdata      one-cycle completion pulse, error flag, load data
//   mem_address/write_data      word-aligned address and store word to memory
//   mem_read/mem_write          access strobes (never both high)
//   mem_data                    read word from memory (byte at address in 31:24)
module data_mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned MEM_BYTES   = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // latched request fields
  logic        r_write, w_write_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic        r_signed, w_signed_nxt;
  logic [1:0]  r_off, w_off_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_old, w_old_nxt;

  // registered outputs
  logic        r_busy, w_busy_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic        r_resp_error, w_resp_error_nxt;
  logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
  logic [31:0] r_mem_address, w_mem_address_nxt;
  logic [31:0] r_mem_write_data, w_mem_write_data_nxt;
  logic        r_mem_read, w_mem_read_nxt;
  logic        r_mem_write, w_mem_write_nxt;

  logic w_req_err;

  // Request legality, evaluated on the live request at acceptance
  assign w_req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || ({req_addr[31:2], 2'b00} >= 32'(MEM_BYTES));

  // Pick the addressed byte/halfword out of a big-endian word and extend it
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off,
                                            input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword of the old word with the store data
  function automatic logic [31:0] f_merge(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  off,
                                          input logic [15:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    res[31:24] = wdata[7:0];
        2'd1:    res[23:16] = wdata[7:0];
        2'd2:    res[15:8]  = wdata[7:0];
        default: res[7:0]   = wdata[7:0];
      endcase
    end else if (off[1]) begin
      res[15:0] = wdata;
    end else begin
      res[31:16] = wdata;
    end
    return res;
  endfunction

  // State and latency counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the counter reloads on every RD/WR entry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            w_state_nxt = S_WR;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = S_RD;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_RD: begin
        if (r_cnt == '0) w_state_nxt = r_write ? S_MERGE : S_RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_MERGE: begin
        w_state_nxt = S_WR;
        w_cnt_nxt   = CNT_LOAD;
      end
      S_WR: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, derived from the
  // upcoming state so strobes and flags line up with it
  always_comb begin
    w_write_nxt          = r_write;
    w_size_nxt           = r_size;
    w_signed_nxt         = r_signed;
    w_off_nxt            = r_off;
    w_wdata_nxt          = r_wdata;
    w_old_nxt            = r_old;
    w_busy_nxt           = (w_state_nxt != S_IDLE);
    w_mem_read_nxt       = (w_state_nxt == S_RD);
    w_mem_write_nxt      = (w_state_nxt == S_WR);
    w_resp_valid_nxt     = (w_state_nxt == S_RESP);
    w_resp_error_nxt     = 1'b0;
    w_resp_rdata_nxt     = r_resp_rdata;
    w_mem_address_nxt    = r_mem_address;
    w_mem_write_data_nxt = r_mem_write_data;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_write_nxt  = req_write;
          w_size_nxt   = req_size;
          w_signed_nxt = req_signed;
          w_off_nxt    = req_addr[1:0];
          w_wdata_nxt  = req_wdata[15:0];
          if (w_req_err) begin
            w_resp_error_nxt = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
            w_mem_address_nxt = {req_addr[31:2], 2'b00};
            if (req_write && (req_size == 2'b10)) w_mem_write_data_nxt = req_wdata;
          end
        end
      end
      S_RD: begin
        if (r_cnt == '0) begin
          w_old_nxt = mem_data;
          if (!r_write) w_resp_rdata_nxt = f_extract(mem_data, r_size, r_off, r_signed);
        end
      end
      S_MERGE: w_mem_write_data_nxt = f_merge(r_old, r_size, r_off, r_wdata);
      S_WR: begin
        if (r_cnt == '0) w_resp_rdata_nxt = '0;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write          <= 1'b0;
      r_size           <= 2'b00;
      r_signed         <= 1'b0;
      r_off            <= 2'b00;
      r_wdata          <= '0;
      r_old            <= '0;
      r_busy           <= 1'b0;
      r_resp_valid     <= 1'b0;
      r_resp_error     <= 1'b0;
      r_resp_rdata     <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
    end else begin
      r_write          <= w_write_nxt;
      r_size           <= w_size_nxt;
      r_signed         <= w_signed_nxt;
      r_off            <= w_off_nxt;
      r_wdata          <= w_wdata_nxt;
      r_old            <= w_old_nxt;
      r_busy           <= w_busy_nxt;
      r_resp_valid     <= w_resp_valid_nxt;
      r_resp_error     <= w_resp_error_nxt;
      r_resp_rdata     <= w_resp_rdata_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_write_data <= w_mem_write_data_nxt;
      r_mem_read       <= w_mem_read_nxt;
      r_mem_write      <= w_mem_write_nxt;
    end
  end

  assign busy           = r_busy;
  assign resp_valid     = r_resp_valid;
  assign resp_error     = r_resp_error;
  assign resp_rdata     = r_resp_rdata;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Initiator/master side of the data-memory interface.
- Accepts one load or store request at a time from the pipeline MEM stage and drives the word-wide, big-endian, byte-addressed data memory (mem_read/mem_write strobes, fixed access latency, no acknowledge).
- Handles byte, halfword and word accesses, with sign/zero extension on loads and read-modify-write for sub-word stores.
- Reports alignment and range errors instead of issuing bad accesses.

Parameters:
- MEM_LATENCY, 2: clock cycles a strobe is held per memory access (minimum 1); read data is sampled in the last of these cycles.
- MEM_BYTES, 2048: memory size in bytes; word addresses at or above it are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; accepted only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: sign-extend when 1, zero-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- busy  out  1  high whenever state is not IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  qualifies resp_valid: misaligned, illegal size or out of range.
- resp_rdata  out  32  extended load result; 0 for stores and errors; holds until the next response.
- mem_address  out  32  word-aligned byte address to memory.
- mem_write_data  out  32  word to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_data  in  32  read word from memory, big-endian (byte at address in bits 31:24).

Behaviour:
- Reset (async, rst_n low): state IDLE, latency counter 0, all outputs 0. Strobes drop immediately. An in-flight request is abandoned with no response; a partial memory write is permitted.
- States: IDLE, RD, MERGE, WR, RESP. All outputs are registered.
- Acceptance: in IDLE with req_valid=1 at a rising edge, request fields are latched. req_valid in any other state is ignored.
- Error check at acceptance, in this order:
  - req_size=11 is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=00 is an error.
  - {addr[31:2],00} >= MEM_BYTES is an error.
  - On error: go to RESP with resp_error=1, resp_rdata=0 and no strobe.
- Legal request: mem_address={addr[31:2],2'b00}. mem_address and mem_write_data stay stable whenever either strobe is high.
- Load: RD holds mem_read=1 for MEM_LATENCY cycles. In the last RD cycle, mem_data is captured and extracted:
  - Byte offset k selects bits [31-8k:24-8k].
  - Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
  - Result is extended per req_signed.
  - Then RESP.
- Word store: WR holds mem_write=1, mem_write_data=req_wdata for MEM_LATENCY cycles, then RESP.
- Sub-word store:
  - RD for MEM_LATENCY cycles captures the old word.
  - MERGE (1 cycle, both strobes 0) replaces the addressed byte or halfword with req_wdata[7:0] or [15:0] and loads mem_write_data.
  - WR for MEM_LATENCY cycles, then RESP.
- mem_read and mem_write are never high in the same cycle.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_error is 0 on success. No new request is accepted in RESP.
- Latency from the accepting edge to the resp_valid cycle, counted in edges:
  - Error: 1.
  - Load or word store: MEM_LATENCY+1.
  - Sub-word store: 2*MEM_LATENCY+2.
- Counter width: enough bits for MEM_LATENCY. The count reloads on every RD or WR entry.

Test Plan:
- Word load: memory word 0xDEADBEEF at 0x10; lw 0x10 -> mem_read high for exactly 2 cycles with mem_address=0x10, mem_write=0; resp_valid pulse 3 edges after acceptance; resp_rdata=0xDEADBEEF, resp_error=0.
- Sub-word loads on the same word:
  - lb signed 0x11 -> 0xFFFFFFAD.
  - lbu 0x11 -> 0x000000AD.
  - lh signed 0x12 -> 0xFFFFBEEF.
  - lhu 0x10 -> 0x0000DEAD.
- Byte store: sb 0x13 with req_wdata=0x12345655 -> read phase (2 cycles), 1 idle cycle, write phase (2 cycles) with mem_write_data=0xDEADBE55; strobes never overlap; resp after 6 edges; subsequent lw 0x10 returns 0xDEADBE55.
- Errors, each giving resp_error=1, resp_valid one edge after acceptance, no strobes, resp_rdata=0:
  - lw 0x12.
  - lh 0x11.
  - req_size=11.
  - lw 0x800.
- Reset mid-operation: sh in progress; rst_n low during WR -> mem_write, busy and resp_valid go 0 without waiting for a clock edge; after release, lw 0x20 completes normally.
- Busy handling: req_valid held high continuously with changing fields -> only the request present at each IDLE edge is accepted; one resp_valid per accepted request; busy high from the edge after acceptance through the RESP cycle.
